// File: rtl/core_defines.sv
// Shared encodings for the execute stage: mul/div opcodes, FSM states,
// ALU opcodes and the writeback-source mux constants.
package core_defines;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic WB_SX_ALU = 1'b0;
    localparam logic WB_SX_MD  = 1'b1;

    // Opcode bit 2 separates the divide family from the multiply family.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/core_alu.sv
// Single-cycle integer ALU used by the execute stage for non-mul/div ops.
module core_alu
    import core_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt_s;

    assign shamt_s = b_i[SH_W-1:0];

    // Operation decode; unknown opcodes yield zero.
    always_comb begin
        result_o = '0;
        case (alu_op_e'(op_i))
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt_s;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt_s;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt_s);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/core_md_unit.sv
// Iterative mul/div engine: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on the result.
module core_md_unit
    import core_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic            ack_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output md_state_e       state_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    md_state_e        state_q, state_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;

    logic             a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, b_zero_s, neg_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s;
    logic [XLEN:0]    mul_sum_s, div_sh_s, div_diff_s;
    logic [2*XLEN-1:0] prod_neg_s;

    // Operand signedness, magnitudes and the result-negate flag at issue.
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (md_op_e'(op_i))
            MD_MULH, MD_DIV, MD_REM: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b1;
            end
            MD_MULHSU: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b0;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        a_neg_s  = a_sgn_s & a_i[XLEN-1];
        b_neg_s  = b_sgn_s & b_i[XLEN-1];
        a_mag_s  = a_neg_s ? (~a_i + ONE) : a_i;
        b_mag_s  = b_neg_s ? (~b_i + ONE) : b_i;
        b_zero_s = (b_i == '0);
        // Divide-by-zero keeps the raw all-ones quotient; remainder follows the dividend.
        case (md_op_e'(op_i))
            MD_DIV, MD_DIVU: neg_s = (a_neg_s ^ b_neg_s) & ~b_zero_s;
            MD_REM, MD_REMU: neg_s = a_neg_s;
            default:         neg_s = a_neg_s ^ b_neg_s;
        endcase
    end

    // Engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opd_q   <= opd_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
        end
    end

    // Next-state and per-iteration datapath.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opd_d      = opd_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
        div_sh_s   = {hi_q, lo_q[XLEN-1]};
        div_diff_s = div_sh_s - {1'b0, opd_q};
        if (kill_i) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_d = MD_BUSY;
                        op_d    = op_i;
                        neg_d   = neg_s;
                        cnt_d   = CNT_W'(XLEN - 1);
                        hi_d    = '0;
                        // Divide shifts the dividend out of lo; multiply consumes the multiplier from lo.
                        if (md_is_div(op_i)) begin
                            lo_d  = a_mag_s;
                            opd_d = b_mag_s;
                        end else begin
                            lo_d  = b_mag_s;
                            opd_d = a_mag_s;
                        end
                    end else begin
                        state_d = MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (md_is_div(op_q)) begin
                        if (!div_diff_s[XLEN]) begin
                            hi_d = div_diff_s[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = div_sh_s[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum_s[XLEN:1];
                        lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = MD_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    if (ack_i) begin
                        state_d = MD_IDLE;
                    end else begin
                        state_d = MD_DONE;
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // Final result selection with sign fix-up.
    always_comb begin
        prod_neg_s = ~{hi_q, lo_q} + {{XLEN{1'b0}}, ONE};
        result_o   = '0;
        case (md_op_e'(op_q))
            MD_MUL:                        result_o = neg_q ? prod_neg_s[XLEN-1:0] : lo_q;
            MD_MULH, MD_MULHSU, MD_MULHU:  result_o = neg_q ? prod_neg_s[2*XLEN-1:XLEN] : hi_q;
            MD_DIV, MD_DIVU:               result_o = neg_q ? (~lo_q + ONE) : lo_q;
            MD_REM, MD_REMU:               result_o = neg_q ? (~hi_q + ONE) : hi_q;
            default:                       result_o = '0;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/core_exe_md_s.sv
// Execute stage: bypass operand select, single-cycle ALU, iterative mul/div
// with upstream stall, and a registered writeback bundle.
module core_exe_md_s
    import core_defines::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int RA_W    = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             exe_enb,
    input  logic                             exe_kill,
    input  logic                             exe_val_inst_in,
    input  logic                             exe_we_reg_file_in,
    input  logic [RA_W-1:0]                  exe_rd_in,
    input  logic [3:0]                       exe_alu_op_in,
    input  logic                             exe_md_val_in,
    input  logic [2:0]                       exe_md_op_in,
    input  logic [XLEN-1:0]                  exe_src1_in,
    input  logic [XLEN-1:0]                  exe_src2_in,
    input  logic [$clog2(NUM_FWD+1)-1:0]     exe_fwd_sel1_in,
    input  logic [$clog2(NUM_FWD+1)-1:0]     exe_fwd_sel2_in,
    input  logic [NUM_FWD*XLEN-1:0]          exe_fwd_data_in,
    output logic [XLEN-1:0]                  exe_result_out_reg,
    output logic [RA_W-1:0]                  exe_rd_out_reg,
    output logic                             exe_we_reg_file_out_reg,
    output logic                             exe_val_inst_out_reg,
    output logic                             exe2haz_stall_out
);

    localparam int SEL_W = $clog2(NUM_FWD + 1);

    // Select k picks bypass slot k-1; zero or out-of-range keeps the register-file value.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [SEL_W-1:0]        sel,
        input logic [XLEN-1:0]         rf,
        input logic [NUM_FWD*XLEN-1:0] fwd
    );
        logic [XLEN-1:0] v;
        v = rf;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                v = fwd[k*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    logic [XLEN-1:0] op1_s, op2_s, alu_res_s, md_res_s;
    md_state_e       md_state_s;
    logic            md_req_s, md_start_s, stall_s, wb_sel_s;
    logic            run_q;
    logic [XLEN-1:0] result_q, result_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic            we_q, we_d, val_q, val_d;

    assign op1_s = pick_operand(exe_fwd_sel1_in, exe_src1_in, exe_fwd_data_in);
    assign op2_s = pick_operand(exe_fwd_sel2_in, exe_src2_in, exe_fwd_data_in);

    // run_q is cleared asynchronously so stall reads 0 while reset is applied.
    assign md_req_s   = run_q & exe_md_val_in & exe_val_inst_in;
    assign md_start_s = md_req_s & ~exe_kill;
    assign stall_s    = md_req_s & (md_state_s != MD_DONE);
    assign wb_sel_s   = (md_req_s && (md_state_s == MD_DONE)) ? WB_SX_MD : WB_SX_ALU;

    core_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op_i    (exe_alu_op_in),
        .a_i     (op1_s),
        .b_i     (op2_s),
        .result_o(alu_res_s)
    );

    core_md_unit #(
        .XLEN(XLEN)
    ) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (md_start_s),
        .kill_i  (exe_kill),
        .ack_i   (exe_enb),
        .op_i    (exe_md_op_in),
        .a_i     (op1_s),
        .b_i     (op2_s),
        .state_o (md_state_s),
        .result_o(md_res_s)
    );

    // Writeback bundle next-state: kill beats advance, stall inserts a bubble.
    always_comb begin
        result_d = result_q;
        rd_d     = rd_q;
        we_d     = we_q;
        val_d    = val_q;
        if (exe_kill) begin
            we_d  = 1'b0;
            val_d = 1'b0;
        end else if (exe_enb) begin
            if (stall_s) begin
                we_d  = 1'b0;
                val_d = 1'b0;
            end else begin
                result_d = (wb_sel_s == WB_SX_MD) ? md_res_s : alu_res_s;
                rd_d     = exe_rd_in;
                we_d     = exe_we_reg_file_in & exe_val_inst_in;
                val_d    = exe_val_inst_in;
            end
        end else begin
            result_d = result_q;
            rd_d     = rd_q;
        end
    end

    // Writeback bundle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            val_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            val_q    <= val_d;
            run_q    <= 1'b1;
        end
    end

    assign exe_result_out_reg      = result_q;
    assign exe_rd_out_reg          = rd_q;
    assign exe_we_reg_file_out_reg = we_q;
    assign exe_val_inst_out_reg    = val_q;
    assign exe2haz_stall_out       = stall_s;

endmodule

// File: tb/tb_core_exe_md_s.sv
// Directed bench for core_exe_md_s: ALU, bypass, mul/div corner cases,
// kill, DONE hold, reset mid-operation and back-to-back mul/div.
module tb_core_exe_md_s;

    logic        clk;
    logic        rst_n;
    logic        exe_enb, exe_kill, exe_val_inst_in, exe_we_reg_file_in;
    logic [4:0]  exe_rd_in;
    logic [3:0]  exe_alu_op_in;
    logic        exe_md_val_in;
    logic [2:0]  exe_md_op_in;
    logic [31:0] exe_src1_in, exe_src2_in;
    logic [1:0]  exe_fwd_sel1_in, exe_fwd_sel2_in;
    logic [63:0] exe_fwd_data_in;
    logic [31:0] exe_result_out_reg;
    logic [4:0]  exe_rd_out_reg;
    logic        exe_we_reg_file_out_reg, exe_val_inst_out_reg, exe2haz_stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    core_exe_md_s #(.XLEN(32), .NUM_FWD(2), .RA_W(5)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .exe_enb                (exe_enb),
        .exe_kill               (exe_kill),
        .exe_val_inst_in        (exe_val_inst_in),
        .exe_we_reg_file_in     (exe_we_reg_file_in),
        .exe_rd_in              (exe_rd_in),
        .exe_alu_op_in          (exe_alu_op_in),
        .exe_md_val_in          (exe_md_val_in),
        .exe_md_op_in           (exe_md_op_in),
        .exe_src1_in            (exe_src1_in),
        .exe_src2_in            (exe_src2_in),
        .exe_fwd_sel1_in        (exe_fwd_sel1_in),
        .exe_fwd_sel2_in        (exe_fwd_sel2_in),
        .exe_fwd_data_in        (exe_fwd_data_in),
        .exe_result_out_reg     (exe_result_out_reg),
        .exe_rd_out_reg         (exe_rd_out_reg),
        .exe_we_reg_file_out_reg(exe_we_reg_file_out_reg),
        .exe_val_inst_out_reg   (exe_val_inst_out_reg),
        .exe2haz_stall_out      (exe2haz_stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] s1, input logic [1:0] s2, input logic [4:0] rd);
        exe_md_val_in = 1'b0; exe_val_inst_in = 1'b1; exe_we_reg_file_in = 1'b1;
        exe_alu_op_in = op; exe_src1_in = a; exe_src2_in = b;
        exe_fwd_sel1_in = s1; exe_fwd_sel2_in = s2; exe_rd_in = rd;
        exe_enb = 1'b1; exe_kill = 1'b0;
        #1;
    endtask

    task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic enb);
        exe_md_val_in = 1'b1; exe_val_inst_in = 1'b1; exe_we_reg_file_in = 1'b1;
        exe_md_op_in = op; exe_src1_in = a; exe_src2_in = b; exe_alu_op_in = 4'd0;
        exe_fwd_sel1_in = 2'd0; exe_fwd_sel2_in = 2'd0; exe_rd_in = 5'd9;
        exe_enb = enb; exe_kill = 1'b0;
        #1;
    endtask

    task automatic drive_idle();
        exe_md_val_in = 1'b0; exe_val_inst_in = 1'b0; exe_we_reg_file_in = 1'b0;
        exe_enb = 1'b0; exe_kill = 1'b0;
        #1;
    endtask

    // Issues one md op with exe_enb=1, counts stall cycles (bounded) and returns the written-back result.
    task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [31:0] res, output logic vout);
        drive_md(op, a, b, 1'b1);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            if (!exe2haz_stall_out) break;
            stalls++;
            tick();
        end
        tick();
        res  = exe_result_out_reg;
        vout = exe_val_inst_out_reg;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        n_checks++; if (exe_result_out_reg !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", exe_result_out_reg); end
        n_checks++; if (exe_val_inst_out_reg !== 1'b0 || exe_we_reg_file_out_reg !== 1'b0) begin n_fail++; $display("FAIL reset_val_we: got %b%b expected 00", exe_val_inst_out_reg, exe_we_reg_file_out_reg); end
        n_checks++; if (exe_rd_out_reg !== 5'd0 || exe2haz_stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_rd_stall: got rd=%0d stall=%b expected 0 0", exe_rd_out_reg, exe2haz_stall_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        exe_fwd_data_in = 64'h0000_0010_0000_0055;
        drive_alu(4'd0, 32'd5, 32'd7, 2'd0, 2'd0, 5'd3);
        n_checks++; if (exe2haz_stall_out !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b expected 0", exe2haz_stall_out); end
        tick();
        n_checks++; if (exe_result_out_reg !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h expected 0000000c", exe_result_out_reg); end
        n_checks++; if (exe_val_inst_out_reg !== 1'b1 || exe_we_reg_file_out_reg !== 1'b1 || exe_rd_out_reg !== 5'd3) begin n_fail++; $display("FAIL add_ctrl: got val=%b we=%b rd=%0d expected 1 1 3", exe_val_inst_out_reg, exe_we_reg_file_out_reg, exe_rd_out_reg); end
        drive_alu(4'd1, 32'd5, 32'd7, 2'd0, 2'd0, 5'd4);
        tick();
        n_checks++; if (exe_result_out_reg !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result: got %h expected fffffffe", exe_result_out_reg); end
        drive_alu(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0, 2'd0, 5'd4);
        tick();
        n_checks++; if (exe_result_out_reg !== 32'h0FF0_0FF0) begin n_fail++; $display("FAIL xor_result: got %h expected 0ff00ff0", exe_result_out_reg); end
    endtask

    task automatic test_forward();
        exe_fwd_data_in = 64'h0000_0010_0000_0055;
        drive_alu(4'd0, 32'h99, 32'd1, 2'd2, 2'd0, 5'd5);
        tick();
        n_checks++; if (exe_result_out_reg !== 32'h11) begin n_fail++; $display("FAIL fwd_slot1: got %h expected 00000011", exe_result_out_reg); end
        drive_alu(4'd0, 32'h99, 32'd1, 2'd0, 2'd1, 5'd5);
        tick();
        n_checks++; if (exe_result_out_reg !== 32'hEE) begin n_fail++; $display("FAIL fwd_slot0: got %h expected 000000ee", exe_result_out_reg); end
        drive_alu(4'd0, 32'h99, 32'd1, 2'd3, 2'd0, 5'd5);
        tick();
        n_checks++; if (exe_result_out_reg !== 32'h9A) begin n_fail++; $display("FAIL fwd_out_of_range: got %h expected 0000009a", exe_result_out_reg); end
    endtask

    task automatic test_md_corners();
        int st; logic [31:0] r; logic v;
        md_run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, st, r, v);
        n_checks++; if (st !== 33) begin n_fail++; $display("FAIL div_ovf_stall: got %0d cycles expected 33", st); end
        n_checks++; if (r !== 32'h8000_0000 || v !== 1'b1) begin n_fail++; $display("FAIL div_ovf: got %h val=%b expected 80000000 1", r, v); end
        md_run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, st, r, v);
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rem_ovf: got %h expected 00000000", r); end
        md_run(3'd5, 32'd7, 32'd0, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero: got %h expected ffffffff", r); end
        md_run(3'd7, 32'd7, 32'd0, st, r, v);
        n_checks++; if (r !== 32'd7) begin n_fail++; $display("FAIL remu_zero: got %h expected 00000007", r); end
        md_run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max: got %h expected fffffffe", r); end
        md_run(3'd1, 32'hFFFF_FFFD, 32'd5, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_neg: got %h expected ffffffff", r); end
        md_run(3'd4, 32'd100, 32'd0, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero: got %h expected ffffffff", r); end
        drive_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] r; logic v;
        md_run(3'd0, 32'hFFFF_FFFD, 32'd5, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFF1 || st !== 33) begin n_fail++; $display("FAIL b2b_mul: got %h after %0d stalls expected fffffff1 after 33", r, st); end
        md_run(3'd4, 32'hFFFF_FFF9, 32'd2, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFFD || st !== 33) begin n_fail++; $display("FAIL b2b_div: got %h after %0d stalls expected fffffffd after 33", r, st); end
        md_run(3'd6, 32'hFFFF_FFF9, 32'd2, st, r, v);
        n_checks++; if (r !== 32'hFFFF_FFFF || st !== 33) begin n_fail++; $display("FAIL b2b_rem: got %h after %0d stalls expected ffffffff after 33", r, st); end
        drive_idle();
        tick();
    endtask

    task automatic test_done_hold();
        int n;
        drive_alu(4'd0, 32'd1, 32'd1, 2'd0, 2'd0, 5'd2);
        tick();
        drive_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tick();
        n_checks++; if (exe_val_inst_out_reg !== 1'b0 || exe_we_reg_file_out_reg !== 1'b0) begin n_fail++; $display("FAIL stall_bubble: got val=%b we=%b expected 0 0", exe_val_inst_out_reg, exe_we_reg_file_out_reg); end
        n = 0;
        while (exe2haz_stall_out === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        exe_enb = 1'b0;
        repeat (3) tick();
        n_checks++; if (exe2haz_stall_out !== 1'b0 || exe_val_inst_out_reg !== 1'b0) begin n_fail++; $display("FAIL done_hold: got stall=%b val=%b expected 0 0", exe2haz_stall_out, exe_val_inst_out_reg); end
        exe_enb = 1'b1;
        tick();
        n_checks++; if (exe_result_out_reg !== 32'hFFFF_FFFE || exe_val_inst_out_reg !== 1'b1) begin n_fail++; $display("FAIL done_release: got %h val=%b expected fffffffe 1", exe_result_out_reg, exe_val_inst_out_reg); end
        drive_idle();
        tick();
    endtask

    task automatic test_kill();
        drive_alu(4'd0, 32'd3, 32'd4, 2'd0, 2'd0, 5'd6);
        tick();
        drive_md(3'd4, 32'd1000, 32'd3, 1'b0);
        tick();
        repeat (9) tick();
        n_checks++; if (exe_val_inst_out_reg !== 1'b1 || exe2haz_stall_out !== 1'b1) begin n_fail++; $display("FAIL kill_pre: got val=%b stall=%b expected 1 1", exe_val_inst_out_reg, exe2haz_stall_out); end
        exe_kill = 1'b1;
        tick();
        n_checks++; if (exe_val_inst_out_reg !== 1'b0 || exe_we_reg_file_out_reg !== 1'b0) begin n_fail++; $display("FAIL kill_bubble: got val=%b we=%b expected 0 0", exe_val_inst_out_reg, exe_we_reg_file_out_reg); end
        drive_alu(4'd0, 32'd10, 32'd20, 2'd0, 2'd0, 5'd7);
        n_checks++; if (exe2haz_stall_out !== 1'b0) begin n_fail++; $display("FAIL kill_stall_drop: got %b expected 0", exe2haz_stall_out); end
        tick();
        n_checks++; if (exe_result_out_reg !== 32'd30 || exe_val_inst_out_reg !== 1'b1) begin n_fail++; $display("FAIL kill_next_add: got %h val=%b expected 0000001e 1", exe_result_out_reg, exe_val_inst_out_reg); end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_busy();
        int st; logic [31:0] r; logic v;
        drive_alu(4'd0, 32'd1, 32'd2, 2'd0, 2'd0, 5'd8);
        tick();
        drive_md(3'd0, 32'd6, 32'd7, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (exe_result_out_reg !== 32'd0 || exe_rd_out_reg !== 5'd0) begin n_fail++; $display("FAIL rst_busy_data: got %h rd=%0d expected 0 0", exe_result_out_reg, exe_rd_out_reg); end
        n_checks++; if (exe_val_inst_out_reg !== 1'b0 || exe_we_reg_file_out_reg !== 1'b0 || exe2haz_stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ctrl: got val=%b we=%b stall=%b expected 0 0 0", exe_val_inst_out_reg, exe_we_reg_file_out_reg, exe2haz_stall_out); end
        drive_idle();
        tick();
        rst_n = 1'b1;
        tick();
        md_run(3'd0, 32'd6, 32'd7, st, r, v);
        n_checks++; if (r !== 32'd42 || st !== 33) begin n_fail++; $display("FAIL rst_busy_restart: got %h after %0d stalls expected 0000002a after 33", r, st); end
        drive_idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        exe_enb = 1'b0; exe_kill = 1'b0; exe_val_inst_in = 1'b0; exe_we_reg_file_in = 1'b0;
        exe_rd_in = 5'd0; exe_alu_op_in = 4'd0; exe_md_val_in = 1'b0; exe_md_op_in = 3'd0;
        exe_src1_in = 32'd0; exe_src2_in = 32'd0; exe_fwd_sel1_in = 2'd0; exe_fwd_sel2_in = 2'd0;
        exe_fwd_data_in = 64'd0;
        test_reset();
        test_alu();
        test_forward();
        test_md_corners();
        test_back_to_back();
        test_done_hold();
        test_kill();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_exe_md_s.md
CORE_EXE_MD_S -- requirements
Module: core_exe_md_s

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of bypass sources.
REQ-003 SHALL have parameter RA_W, default 5, register-address width.
REQ-004 SHALL have port clk, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port exe_enb, input, 1, pipeline advance enable.
REQ-007 SHALL have port exe_kill, input, 1, flush current instruction.
REQ-008 SHALL have port exe_val_inst_in, input, 1, instruction valid.
REQ-009 SHALL have port exe_we_reg_file_in, input, 1, writeback enable.
REQ-010 SHALL have port exe_rd_in, input, RA_W, destination register.
REQ-011 SHALL have port exe_alu_op_in, input, 4, ALU operation.
REQ-012 SHALL have port exe_md_val_in, input, 1, instruction is mul/div.
REQ-013 SHALL have port exe_md_op_in, input, 3, MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU.
REQ-014 SHALL have port exe_src1_in, input, XLEN, register-file operand 1.
REQ-015 SHALL have port exe_src2_in, input, XLEN, register-file operand 2.
REQ-016 SHALL have port exe_fwd_sel1_in, input, clog2(NUM_FWD+1), operand-1 source select.
REQ-017 SHALL have port exe_fwd_sel2_in, input, clog2(NUM_FWD+1), operand-2 source select.
REQ-018 SHALL have port exe_fwd_data_in, input, NUM_FWD*XLEN, packed bypass values, slot 0 at LSBs.
REQ-019 SHALL have port exe_result_out_reg, output, XLEN, registered result.
REQ-020 SHALL have port exe_rd_out_reg, output, RA_W, registered rd.
REQ-021 SHALL have port exe_we_reg_file_out_reg, output, 1, registered writeback enable.
REQ-022 SHALL have port exe_val_inst_out_reg, output, 1, registered valid.
REQ-023 SHALL have port exe2haz_stall_out, output, 1, mul/div busy, freeze upstream.

Function
REQ-024 Operand select SHALL be combinational: sel 0 -> exe_srcN_in; sel k (1..NUM_FWD) -> fwd slot k-1; out-of-range sel -> exe_srcN_in.
REQ-025 Non-md instructions SHALL produce the ALU result with zero stall; the output register loads on the exe_enb edge.
REQ-026 Mul/div FSM SHALL have states IDLE, BUSY, DONE.
REQ-027 IDLE->BUSY on exe_md_val_in & exe_val_inst_in & ~exe_kill; operands latched; counter loaded with XLEN-1.
REQ-028 BUSY: one iteration per cycle (shift-add multiply, restoring divide); counter decrements; at 0 the FSM goes to DONE.
REQ-029 DONE: the output register loads the md result when exe_enb=1, then the FSM goes to IDLE; DONE holds while exe_enb=0.
REQ-030 exe2haz_stall_out SHALL be exe_md_val_in & exe_val_inst_in & (state != DONE), so it is high for exactly XLEN+1 cycles per md instruction.
REQ-031 While stall=1 the output register SHALL load a bubble (val=0, we=0) when exe_enb=1.
REQ-032 Signed ops SHALL operate on magnitudes with result sign fix-up; MULH* return the upper XLEN bits of the 2*XLEN product.
REQ-033 Divide-by-zero SHALL return quotient all-ones and remainder = dividend.
REQ-034 Signed overflow (MIN / -1) SHALL return quotient MIN and remainder 0.
REQ-035 exe_kill SHALL take priority over exe_enb: the FSM goes to IDLE next cycle, the output register loads a bubble, and stall drops the cycle after kill.
REQ-036 A back-to-back md instruction SHALL be accepted from IDLE on the cycle after DONE.

Reset
REQ-037 rst_n low SHALL asynchronously force all outputs to 0 and FSM=IDLE; reset mid-BUSY SHALL discard the operation.

Structure
REQ-038 md_op encodings, FSM state encodings and the WB_SX/mux constants SHALL live in a shared core_defines package.
REQ-039 The iterative engine SHALL be one sub-module, core_md_unit; the existing core_alu SHALL be instantiated for ALU ops.

Verification
REQ-040 ADD 5+7, sel1=0, sel2=0, exe_enb=1 -> result 12 the next edge, stall never high.
REQ-041 sel1=2 with fwd slot1=0x10, src1=0x99, ADD src2=1 -> result 0x11.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> stall high 33 cycles, result 0x80000000; REM of the same operands -> 0.
REQ-043 DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-044 exe_kill at BUSY cycle 10 -> val_out=0 next edge, stall low after one cycle, the following ADD completes normally.
REQ-045 rst_n low during BUSY -> all outputs 0 immediately, FSM IDLE, stall 0.
